// File: rtl/char_uart_streamer_if.sv
// ============================================================================
// Module   : char_uart_streamer_if
// Brief    : Buffer read port, start control and UART/status outputs of the
//            character streamer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface char_uart_streamer_if #(
    parameter int ADDR_WIDTH = 7
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic                  tx;
    logic                  busy;
    logic                  byte_sent;
    logic                  done;
    logic [ADDR_WIDTH:0]   sent_count;

    modport master (
        input  start, rd_data,
        output rd_addr, tx, busy, byte_sent, done, sent_count
    );

    modport slave (
        output start, rd_data,
        input  rd_addr, tx, busy, byte_sent, done, sent_count
    );
endinterface

`default_nettype wire

// File: rtl/char_uart_streamer.sv
// ============================================================================
// Module   : char_uart_streamer
// Brief    : Drains the CPU character buffer through a synchronous read port
//            and sends each byte as 8N1 UART on a single pin.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module char_uart_streamer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int NUM_CHARS    = 100,
    parameter int ADDR_WIDTH   = 7,
    parameter int STOP_ON_NUL  = 1
) (
    input wire                    clock,
    input wire                    reset,
    char_uart_streamer_if.master  bus
);

    localparam int                  CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]       c_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(NUM_CHARS - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_LOAD  = 3'd2;
    localparam logic [2:0] c_S_START = 3'd3;
    localparam logic [2:0] c_S_DATA  = 3'd4;
    localparam logic [2:0] c_S_STOP  = 3'd5;
    localparam logic [2:0] c_S_DONE  = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [CW-1:0]         r_baud;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic [7:0]            w_shift_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH:0]   r_sent_count;
    logic                  r_tx;
    logic                  r_byte_sent;
    logic                  w_tx_next;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_baud_last;
    logic                  w_nul;

    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_nul       = (STOP_ON_NUL != 0) && (bus.rd_data == 8'h00);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (bus.start) w_state_next = c_S_FETCH;
            c_S_FETCH: w_state_next = c_S_LOAD;
            c_S_LOAD:  w_state_next = w_nul ? c_S_DONE : c_S_START;
            c_S_START: if (w_baud_last) w_state_next = c_S_DATA;
            c_S_DATA:  if (w_baud_last && (r_bit == 3'd7)) w_state_next = c_S_STOP;
            c_S_STOP:  if (w_baud_last) w_state_next = (r_idx == c_LAST_IDX) ? c_S_DONE : c_S_FETCH;
            c_S_DONE:  if (!bus.start) w_state_next = c_S_IDLE;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    // tx is registered from the next state so the pin never glitches on decode.
    always_comb begin
        w_busy       = (r_state == c_S_FETCH) || (r_state == c_S_LOAD) || (r_state == c_S_START)
                    || (r_state == c_S_DATA)  || (r_state == c_S_STOP);
        w_done       = (r_state == c_S_DONE);
        w_shift_next = r_shift;
        if (r_state == c_S_LOAD) begin
            w_shift_next = bus.rd_data;
        end else if ((r_state == c_S_DATA) && w_baud_last) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
        w_tx_next = 1'b1;
        if (w_state_next == c_S_START) begin
            w_tx_next = 1'b0;
        end else if (w_state_next == c_S_DATA) begin
            w_tx_next = w_shift_next[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_sent_count <= '0;
            r_tx         <= 1'b1;
            r_byte_sent  <= 1'b0;
        end else begin
            r_tx        <= w_tx_next;
            r_shift     <= w_shift_next;
            r_byte_sent <= (r_state == c_S_STOP) && w_baud_last;

            if ((r_state == c_S_START) || (r_state == c_S_DATA) || (r_state == c_S_STOP)) begin
                r_baud <= w_baud_last ? '0 : r_baud + 1'b1;
            end else begin
                r_baud <= '0;
            end

            if (r_state == c_S_DATA) begin
                if (w_baud_last) r_bit <= r_bit + 3'd1;
            end else begin
                r_bit <= '0;
            end

            if ((r_state == c_S_IDLE) && bus.start) begin
                r_idx        <= '0;
                r_sent_count <= '0;
            end else if ((r_state == c_S_STOP) && w_baud_last) begin
                r_sent_count <= r_sent_count + 1'b1;
                // Address saturates at the last slot so it never leaves the buffer.
                if (r_idx != c_LAST_IDX) r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.rd_addr    = r_idx;
    assign bus.tx         = r_tx;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.byte_sent  = r_byte_sent;
    assign bus.sent_count = r_sent_count;

endmodule

`default_nettype wire

// File: tb/tb_char_uart_streamer.sv
// ============================================================================
// Module   : tb_char_uart_streamer
// Brief    : Self-checking bench for char_uart_streamer with a frame-level
//            reference model of the expected UART line and status outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_char_uart_streamer;

    localparam int CPB   = 4;
    localparam int NCH   = 3;
    localparam int AW    = 2;
    localparam int FRAME = 10 * CPB + 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    int   n_err = 0;
    int   n_chk = 0;

    logic [7:0] mem0 [0:3];
    logic [7:0] mem1 [0:3];
    logic [7:0] m_buf [0:2];

    always #5 clk = ~clk;

    char_uart_streamer_if #(.ADDR_WIDTH(AW)) if0 ();
    char_uart_streamer_if #(.ADDR_WIDTH(AW)) if1 ();

    assign if0.start = start & ~sel;
    assign if1.start = start & sel;

    always @(posedge clk) begin
        if0.rd_data <= mem0[if0.rd_addr];
        if1.rd_data <= mem1[if1.rd_addr];
    end

    char_uart_streamer #(.CLKS_PER_BIT(CPB), .NUM_CHARS(NCH), .ADDR_WIDTH(AW), .STOP_ON_NUL(0))
        dut0 (.clock(clk), .reset(rst), .bus(if0));
    char_uart_streamer #(.CLKS_PER_BIT(CPB), .NUM_CHARS(NCH), .ADDR_WIDTH(AW), .STOP_ON_NUL(1))
        dut1 (.clock(clk), .reset(rst), .bus(if1));

    logic          o_tx, o_busy, o_done, o_bs;
    logic [AW-1:0] o_addr;
    logic [AW:0]   o_cnt;
    assign o_tx   = sel ? if1.tx         : if0.tx;
    assign o_busy = sel ? if1.busy       : if0.busy;
    assign o_done = sel ? if1.done       : if0.done;
    assign o_bs   = sel ? if1.byte_sent  : if0.byte_sent;
    assign o_addr = sel ? if1.rd_addr    : if0.rd_addr;
    assign o_cnt  = sel ? if1.sent_count : if0.sent_count;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        repeat (2) step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_chk++;
            if ({o_tx, o_busy, o_done, o_bs, o_addr, o_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0}) begin
                n_err++;
                $display("FAIL reset[%0d] got tx=%b busy=%b done=%b bs=%b addr=%0d cnt=%0d want 1 0 0 0 0 0",
                         s, o_tx, o_busy, o_done, o_bs, o_addr, o_cnt);
            end
        end
        rst = 1'b0;
        sel = 1'b0;
        step();
    endtask

    // Full transfer with start held; expected line built from the byte list.
    task automatic test_stream(input bit s, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input string tag);
        int nsent, len, max_addr, exp_max, off, bi;
        bit nul_found;
        logic e_tx, e_bs, e_busy, e_done;
        logic [AW:0] e_cnt;
        sel = s;
        m_buf[0] = b0; m_buf[1] = b1; m_buf[2] = b2;
        if (s) begin
            mem1[0] = b0; mem1[1] = b1; mem1[2] = b2; mem1[3] = 8'hFF;
        end else begin
            mem0[0] = b0; mem0[1] = b1; mem0[2] = b2; mem0[3] = 8'hFF;
        end
        nsent = NCH;
        nul_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (s && !nul_found && m_buf[i] == 8'h00) begin
                nul_found = 1'b1;
                nsent = i;
            end
        end
        len      = nul_found ? nsent * FRAME + 2 : NCH * FRAME;
        exp_max  = nul_found ? nsent : NCH - 1;
        max_addr = 0;
        start = 1'b1;
        for (int k = 0; k <= len + 4; k++) begin
            step();
            off = k % FRAME;
            bi  = k / FRAME;
            if (k >= len)                e_tx = 1'b1;
            else if (off < 2)            e_tx = 1'b1;
            else if (off < 2 + CPB)      e_tx = 1'b0;
            else if (off < 2 + 9 * CPB)  e_tx = m_buf[bi][(off - 2 - CPB) / CPB];
            else                         e_tx = 1'b1;
            e_bs   = (k > 0) && (off == 0) && (bi <= nsent);
            e_cnt  = (AW + 1)'((bi < nsent) ? bi : nsent);
            e_busy = (k < len);
            e_done = (k >= len);
            if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
            n_chk++;
            if (o_tx !== e_tx) begin
                n_err++;
                $display("FAIL %s tx k=%0d got %b want %b", tag, k, o_tx, e_tx);
            end
            n_chk++;
            if ({o_bs, o_busy, o_done, o_cnt} !== {e_bs, e_busy, e_done, e_cnt}) begin
                n_err++;
                $display("FAIL %s status k=%0d got bs=%b busy=%b done=%b cnt=%0d want %b %b %b %0d",
                         tag, k, o_bs, o_busy, o_done, o_cnt, e_bs, e_busy, e_done, e_cnt);
            end
        end
        n_chk++;
        if (max_addr != exp_max) begin
            n_err++;
            $display("FAIL %s max_rd_addr got %0d want %0d", tag, max_addr, exp_max);
        end
        start = 1'b0;
        step();
        n_chk++;
        if ({o_done, o_busy, o_tx} !== 3'b001) begin
            n_err++;
            $display("FAIL %s to_idle got done=%b busy=%b tx=%b want 0 0 1", tag, o_done, o_busy, o_tx);
        end
    endtask

    task automatic test_frame_decode();
        int run, gap, t;
        logic [7:0] d;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) mem0[i] = 8'h55;
        start = 1'b1;
        t = 0;
        while (o_tx !== 1'b0 && t < 10) begin step(); t++; end
        n_chk++;
        if (o_tx !== 1'b0) begin
            n_err++;
            $display("FAIL decode first_start got tx=%b want 0", o_tx);
        end
        for (int f = 0; f < NCH; f++) begin
            run = 1;
            step();
            while (o_tx === 1'b0 && run < 20) begin run++; step(); end
            n_chk++;
            if (run != CPB) begin
                n_err++;
                $display("FAIL decode start_len f=%0d got %0d want %0d", f, run, CPB);
            end
            step(); step();
            for (int b = 0; b < 8; b++) begin
                d[b] = o_tx;
                repeat (CPB) step();
            end
            n_chk++;
            if (d !== 8'h55) begin
                n_err++;
                $display("FAIL decode byte f=%0d got %h want 55", f, d);
            end
            n_chk++;
            if (o_tx !== 1'b1) begin
                n_err++;
                $display("FAIL decode stop f=%0d got %b want 1", f, o_tx);
            end
            if (f < NCH - 1) begin
                step(); step();
                gap = 0;
                while (o_tx === 1'b1 && gap < 10) begin gap++; step(); end
                n_chk++;
                if (gap != 2) begin
                    n_err++;
                    $display("FAIL decode gap f=%0d got %0d want 2", f, gap);
                end
            end
        end
        t = 0;
        while (o_done !== 1'b1 && t < 20) begin step(); t++; end
        start = 1'b0;
        step();
    endtask

    task automatic test_hold_start();
        int bad;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) mem0[i] = 8'($urandom_range(0, 255));
        start = 1'b1;
        for (int k = 0; k <= NCH * FRAME; k++) step();
        n_chk++;
        if ({o_done, o_cnt} !== {1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL hold done got done=%b cnt=%0d want 1 3", o_done, o_cnt);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if ({o_done, o_busy, o_bs, o_tx} !== 4'b1001) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_no_repeat got %0d bad cycles want 0", bad);
        end
        start = 1'b0;
        step();
        n_chk++;
        if ({o_done, o_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL hold_release got done=%b busy=%b want 0 0", o_done, o_busy);
        end
        start = 1'b1;
        step();
        n_chk++;
        if ({o_busy, o_addr, o_cnt} !== {1'b1, 2'd0, 3'd0}) begin
            n_err++;
            $display("FAIL hold_restart got busy=%b addr=%0d cnt=%0d want 1 0 0", o_busy, o_addr, o_cnt);
        end
        bad = 0;
        while (o_done !== 1'b1 && bad < 200) begin step(); bad++; end
        n_chk++;
        if (o_done !== 1'b1) begin
            n_err++;
            $display("FAIL hold_restart_done timeout got done=%b want 1", o_done);
        end
        start = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int t;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) mem0[i] = 8'($urandom_range(1, 255));
        start = 1'b1;
        for (int k = 0; k <= FRAME + 2 + 3 * CPB + 1; k++) step();
        n_chk++;
        if ({o_busy, o_addr, o_cnt} !== {1'b1, 2'd1, 3'd1}) begin
            n_err++;
            $display("FAIL rstmid pre got busy=%b addr=%0d cnt=%0d want 1 1 1", o_busy, o_addr, o_cnt);
        end
        rst   = 1'b1;
        start = 1'b0;
        step();
        n_chk++;
        if ({o_tx, o_busy, o_done, o_bs, o_addr, o_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0}) begin
            n_err++;
            $display("FAIL rstmid got tx=%b busy=%b done=%b bs=%b addr=%0d cnt=%0d want 1 0 0 0 0 0",
                     o_tx, o_busy, o_done, o_bs, o_addr, o_cnt);
        end
        rst = 1'b0;
        step();
        n_chk++;
        if ({o_tx, o_busy, o_done} !== 3'b100) begin
            n_err++;
            $display("FAIL rstmid_idle got tx=%b busy=%b done=%b want 1 0 0", o_tx, o_busy, o_done);
        end
        start = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            step();
            if (k == 0) begin
                n_chk++;
                if ({o_busy, o_addr} !== {1'b1, 2'd0}) begin
                    n_err++;
                    $display("FAIL rstmid_restart got busy=%b addr=%0d want 1 0", o_busy, o_addr);
                end
            end else if (k == 2) begin
                n_chk++;
                if (o_tx !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_start_bit got tx=%b want 0", o_tx);
                end
            end
        end
        n_chk++;
        if ({o_bs, o_cnt} !== {1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL rstmid_first_byte got bs=%b cnt=%0d want 1 1", o_bs, o_cnt);
        end
        t = 0;
        while (o_done !== 1'b1 && t < 200) begin step(); t++; end
        start = 1'b0;
        step();
    endtask

    task automatic test_start_pulse();
        int pulses;
        sel = 1'b0;
        for (int i = 0; i < 4; i++) mem0[i] = 8'($urandom_range(0, 255));
        start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= NCH * FRAME; k++) begin
            step();
            if (o_bs === 1'b1) pulses++;
            start = (k == 60);
        end
        n_chk++;
        if ({o_done, o_cnt} !== {1'b1, 3'd3} || pulses != 3) begin
            n_err++;
            $display("FAIL pulse got done=%b cnt=%0d pulses=%0d want 1 3 3", o_done, o_cnt, pulses);
        end
        step();
        n_chk++;
        if ({o_done, o_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL pulse_idle got done=%b busy=%b want 0 0", o_done, o_busy);
        end
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        int zp;
        for (int i = 0; i < 4; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        test_reset();
        test_stream(1'b0, 8'h41, 8'h42, 8'h43, "basic");
        for (int n = 0; n < 2; n++) begin
            r0 = 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            test_stream(1'b0, r0, r1, r2, "rand_send_all");
        end
        test_frame_decode();
        test_stream(1'b1, 8'h48, 8'h00, 8'h41, "nul");
        for (int n = 0; n < 2; n++) begin
            r0 = 8'($urandom_range(1, 255));
            r1 = 8'($urandom_range(1, 255));
            r2 = 8'($urandom_range(1, 255));
            zp = int'($urandom_range(0, 3));
            if (zp == 0) r0 = 8'h00;
            if (zp == 1) r1 = 8'h00;
            if (zp == 2) r2 = 8'h00;
            test_stream(1'b1, r0, r1, r2, "rand_nul");
        end
        test_hold_start();
        test_reset_mid();
        test_start_pulse();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
